// File: rtl/spi_rd_word_packer.sv
// Packs the SPI flash read byte stream into MSB-first 32-bit words behind a small FWFT FIFO.
// Optional incrementing-pattern checker enabled by defining SPI_RD_PATTERN_CHK_EN.
module spi_rd_word_packer #(
  parameter int unsigned BYTE_MAX   = 10,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [7:0]  START_VAL  = 8'h00
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        frame_start,
  input  logic [7:0]  byte_in,
  input  logic        byte_vld,
  output logic [31:0] word_out,
  output logic [3:0]  word_keep,
  output logic        word_last,
  output logic        word_vld,
  input  logic        word_rdy,
  output logic        frame_done,
  output logic        trunc_err,
  output logic        ovf,
  output logic        chk_err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BC_W  = 8;
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(BYTE_MAX - 1);

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_acc;
  logic            w_trunc;
  logic            w_final;
  logic [BC_W-1:0] w_idx;
  logic [BC_W-1:0] r_cnt;
  logic [31:0]     r_pack;
  logic [31:0]     w_base;
  logic [31:0]     w_word;
  logic [3:0]      w_keep;
  logic [1:0]      w_lane;
  logic            w_push;
  word_t           w_entry;
  logic            r_done;
  logic            r_trunc;

  word_t            r_mem [FIFO_DEPTH];
  word_t            w_mem_nxt [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [CNT_W-1:0] r_fcnt;
  logic [CNT_W-1:0] w_fcnt_nxt;
  logic             w_pop;
  logic             w_full;
  logic             w_push_ok;
  logic             w_ovf_set;
  word_t            w_head;
  word_t            r_head;
  logic             r_vld;
  logic             r_ovf;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // A frame_start always wins; a byte arriving with it becomes byte 0 of the new frame.
  always_comb begin
    w_state_nxt = r_state;
    w_acc       = 1'b0;
    w_trunc     = 1'b0;
    w_idx       = r_cnt;
    if (frame_start) begin
      w_trunc     = (r_state == S_COLLECT);
      w_idx       = '0;
      w_acc       = byte_vld;
      w_state_nxt = S_COLLECT;
    end else if (r_state == S_COLLECT) begin
      w_acc = byte_vld;
    end
    w_final = w_acc && (w_idx == LAST_IDX);
    if (w_final) w_state_nxt = S_DONE;
  end

  always_comb begin
    w_base = frame_start ? 32'h0 : r_pack;
    w_lane = w_idx[1:0];
    w_word = w_base;
    w_keep = 4'b1000;
    case (w_lane)
      2'd0: begin w_word[31:24] = byte_in; w_keep = 4'b1000; end
      2'd1: begin w_word[23:16] = byte_in; w_keep = 4'b1100; end
      2'd2: begin w_word[15:8]  = byte_in; w_keep = 4'b1110; end
      default: begin w_word[7:0] = byte_in; w_keep = 4'b1111; end
    endcase
    w_push  = w_acc && ((w_lane == 2'd3) || w_final);
    w_entry = '{data: w_word, keep: w_keep, last: w_final};
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt   <= '0;
      r_pack  <= '0;
      r_done  <= 1'b0;
      r_trunc <= 1'b0;
    end else begin
      r_done  <= w_final;
      r_trunc <= w_trunc;
      if (w_acc) begin
        r_cnt  <= BC_W'(w_idx + BC_W'(1));
        r_pack <= w_push ? 32'h0 : w_word;
      end else if (frame_start) begin
        r_cnt  <= '0;
        r_pack <= '0;
      end
    end
  end

  // FIFO next-state; the head output register is loaded from the post-update head entry.
  always_comb begin
    w_pop     = r_vld && word_rdy;
    w_full    = (r_fcnt == CNT_W'(FIFO_DEPTH));
    w_push_ok = w_push && (!w_full || w_pop);
    w_ovf_set = w_push && w_full && !w_pop;
    w_mem_nxt = r_mem;
    if (w_push_ok) w_mem_nxt[r_wr_ptr] = w_entry;
    w_rd_nxt   = w_pop ? PTR_W'(r_rd_ptr + 1'b1) : r_rd_ptr;
    w_fcnt_nxt = CNT_W'(r_fcnt + CNT_W'(w_push_ok) - CNT_W'(w_pop));
    w_head     = (w_fcnt_nxt != '0) ? w_mem_nxt[w_rd_nxt] : '0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fcnt   <= '0;
      r_head   <= '0;
      r_vld    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_mem    <= w_mem_nxt;
      r_wr_ptr <= w_push_ok ? PTR_W'(r_wr_ptr + 1'b1) : r_wr_ptr;
      r_rd_ptr <= w_rd_nxt;
      r_fcnt   <= w_fcnt_nxt;
      r_head   <= w_head;
      r_vld    <= (w_fcnt_nxt != '0);
      r_ovf    <= r_ovf | w_ovf_set;
    end
  end

`ifdef SPI_RD_PATTERN_CHK_EN
  logic w_chk_hit;
  logic r_chk;

  assign w_chk_hit = w_acc && (byte_in != 8'(START_VAL + w_idx));

  // Sticky within a frame; a new frame clears it unless its first byte already mismatches.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_chk <= 1'b0;
    else         r_chk <= (frame_start ? 1'b0 : r_chk) | w_chk_hit;
  end

  assign chk_err = r_chk;
`else
  logic w_unused_start_val;
  assign w_unused_start_val = ^START_VAL;
  assign chk_err = 1'b0;
`endif

  assign word_out   = r_head.data;
  assign word_keep  = r_head.keep;
  assign word_last  = r_head.last;
  assign word_vld   = r_vld;
  assign frame_done = r_done;
  assign trunc_err  = r_trunc;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_spi_rd_word_packer.sv
// Directed bench for spi_rd_word_packer (BYTE_MAX=10, FIFO_DEPTH=2); collects popped words at negedge.
module tb_spi_rd_word_packer;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_vld = 1'b0;
  logic        word_rdy = 1'b0;
  logic [31:0] word_out;
  logic [3:0]  word_keep;
  logic        word_last;
  logic        word_vld;
  logic        frame_done;
  logic        trunc_err;
  logic        ovf;
  logic        chk_err;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int n_trunc = 0;
  logic [31:0] q_data [$];
  logic [3:0]  q_keep [$];
  logic        q_last [$];

  spi_rd_word_packer #(
    .BYTE_MAX  (10),
    .FIFO_DEPTH(2),
    .START_VAL (8'h00)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .frame_start(frame_start),
    .byte_in    (byte_in),
    .byte_vld   (byte_vld),
    .word_out   (word_out),
    .word_keep  (word_keep),
    .word_last  (word_last),
    .word_vld   (word_vld),
    .word_rdy   (word_rdy),
    .frame_done (frame_done),
    .trunc_err  (trunc_err),
    .ovf        (ovf),
    .chk_err    (chk_err)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (word_vld && word_rdy) begin
      q_data.push_back(word_out);
      q_keep.push_back(word_keep);
      q_last.push_back(word_last);
    end
    if (frame_done) n_done++;
    if (trunc_err)  n_trunc++;
  end

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in  = b;
    byte_vld = 1'b1;
    cyc();
    byte_vld = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic clear_mon();
    q_data.delete();
    q_keep.delete();
    q_last.delete();
    n_done  = 0;
    n_trunc = 0;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    n_cmp++;
    if ({word_vld, word_out, word_keep, word_last} !== 38'h0) begin
      n_err++;
      $display("FAIL reset_word: got vld=%b %h/%b/%b want all zero", word_vld, word_out, word_keep, word_last);
    end
    n_cmp++;
    if ({frame_done, trunc_err, ovf, chk_err} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000", {frame_done, trunc_err, ovf, chk_err});
    end
    sys_rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    logic [31:0] exp_d [3];
    logic [3:0]  exp_k [3];
    logic        exp_l [3];
    exp_d = '{32'h00010203, 32'h04050607, 32'h08090000};
    exp_k = '{4'b1111, 4'b1111, 4'b1100};
    exp_l = '{1'b0, 1'b0, 1'b1};
    clear_mon();
    word_rdy = 1'b1;
    start_frame();
    for (int i = 0; i < 3; i++) send_byte(8'(i));
    n_cmp++;
    if (word_vld !== 1'b0) begin
      n_err++;
      $display("FAIL basic_vld_early: got %b want 0", word_vld);
    end
    send_byte(8'h03);
    n_cmp++;
    if (word_vld !== 1'b1 || word_out !== 32'h00010203) begin
      n_err++;
      $display("FAIL basic_latency: got vld=%b %h want vld=1 00010203", word_vld, word_out);
    end
    for (int i = 4; i < 10; i++) send_byte(8'(i));
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL basic_done_pulse: got %b want 1", frame_done);
    end
    cyc();
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_clear: got %b want 0", frame_done);
    end
    repeat (3) cyc();
    n_cmp++;
    if (q_data.size() != 3 || n_done != 1 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL basic_counts: got words=%0d done=%0d ovf=%b want 3 1 0", q_data.size(), n_done, ovf);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= q_data.size()) begin
        n_err++;
        $display("FAIL basic_word%0d: got none want %h/%b/%b", i, exp_d[i], exp_k[i], exp_l[i]);
      end else if (q_data[i] !== exp_d[i] || q_keep[i] !== exp_k[i] || q_last[i] !== exp_l[i]) begin
        n_err++;
        $display("FAIL basic_word%0d: got %h/%b/%b want %h/%b/%b", i, q_data[i], q_keep[i], q_last[i],
                 exp_d[i], exp_k[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_overflow();
    clear_mon();
    word_rdy = 1'b0;
    start_frame();
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    n_cmp++;
    if (ovf !== 1'b0 || word_vld !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_before: got ovf=%b vld=%b want 0 1", ovf, word_vld);
    end
    send_byte(8'h08);
    send_byte(8'h09);
    n_cmp++;
    if (ovf !== 1'b1 || word_out !== 32'h00010203) begin
      n_err++;
      $display("FAIL ovf_set: got ovf=%b head=%h want 1 00010203", ovf, word_out);
    end
    word_rdy = 1'b1;
    repeat (4) cyc();
    n_cmp++;
    if (q_data.size() != 2 || word_vld !== 1'b0 || ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_drain: got words=%0d vld=%b ovf=%b want 2 0 1", q_data.size(), word_vld, ovf);
    end else begin
      n_cmp++;
      if (q_data[0] !== 32'h00010203 || q_data[1] !== 32'h04050607 || q_last[1] !== 1'b0) begin
        n_err++;
        $display("FAIL ovf_words: got %h %h last=%b want 00010203 04050607 last=0", q_data[0], q_data[1], q_last[1]);
      end
    end
    sys_rst = 1'b1;
    cyc();
    sys_rst = 1'b0;
    cyc();
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_reset: got %b want 0", ovf);
    end
  endtask

  task automatic test_trunc();
    logic [31:0] exp_d [4];
    exp_d = '{32'h00010203, 32'h10111213, 32'h14151617, 32'h18190000};
    clear_mon();
    word_rdy = 1'b1;
    start_frame();
    for (int i = 0; i < 5; i++) send_byte(8'(i));
    start_frame();
    n_cmp++;
    if (trunc_err !== 1'b1) begin
      n_err++;
      $display("FAIL trunc_pulse: got %b want 1", trunc_err);
    end
    send_byte(8'h10);
    n_cmp++;
    if (trunc_err !== 1'b0) begin
      n_err++;
      $display("FAIL trunc_clear: got %b want 0", trunc_err);
    end
    for (int i = 1; i < 10; i++) send_byte(8'(8'h10 + i));
    repeat (3) cyc();
    n_cmp++;
    if (q_data.size() != 4 || n_trunc != 1 || n_done != 1) begin
      n_err++;
      $display("FAIL trunc_counts: got words=%0d trunc=%0d done=%0d want 4 1 1", q_data.size(), n_trunc, n_done);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= q_data.size()) begin
        n_err++;
        $display("FAIL trunc_word%0d: got none want %h", i, exp_d[i]);
      end else if (q_data[i] !== exp_d[i]) begin
        n_err++;
        $display("FAIL trunc_word%0d: got %h want %h", i, q_data[i], exp_d[i]);
      end
    end
    n_cmp++;
    if (q_data.size() == 4 && (q_keep[3] !== 4'b1100 || q_last[3] !== 1'b1)) begin
      n_err++;
      $display("FAIL trunc_tail: got keep=%b last=%b want 1100 1", q_keep[3], q_last[3]);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_d [3];
    exp_d = '{32'h55565758, 32'h595a5b5c, 32'h5d5e0000};
    clear_mon();
    word_rdy    = 1'b1;
    frame_start = 1'b1;
    send_byte(8'h55);
    frame_start = 1'b0;
    for (int i = 1; i < 10; i++) send_byte(8'(8'h55 + i));
    repeat (3) cyc();
    n_cmp++;
    if (q_data.size() != 3 || n_trunc != 0 || n_done != 1) begin
      n_err++;
      $display("FAIL same_counts: got words=%0d trunc=%0d done=%0d want 3 0 1", q_data.size(), n_trunc, n_done);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= q_data.size()) begin
        n_err++;
        $display("FAIL same_word%0d: got none want %h", i, exp_d[i]);
      end else if (q_data[i] !== exp_d[i]) begin
        n_err++;
        $display("FAIL same_word%0d: got %h want %h", i, q_data[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    clear_mon();
    word_rdy = 1'b0;
    start_frame();
    for (int i = 0; i < 6; i++) send_byte(8'(i));
    n_cmp++;
    if (word_vld !== 1'b1 || word_out !== 32'h00010203) begin
      n_err++;
      $display("FAIL arst_pre: got vld=%b %h want 1 00010203", word_vld, word_out);
    end
    #2;
    sys_rst = 1'b1;
    #1;
    n_cmp++;
    if ({word_vld, word_out, word_keep, word_last, frame_done, trunc_err, ovf, chk_err} !== 42'h0) begin
      n_err++;
      $display("FAIL arst_now: got vld=%b %h/%b/%b flags=%b want all zero", word_vld, word_out, word_keep,
               word_last, {frame_done, trunc_err, ovf, chk_err});
    end
    cyc();
    sys_rst  = 1'b0;
    word_rdy = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) send_byte(8'(8'h30 + i));
    repeat (2) cyc();
    n_cmp++;
    if (q_data.size() != 0 || word_vld !== 1'b0) begin
      n_err++;
      $display("FAIL arst_ignore: got words=%0d vld=%b want 0 0", q_data.size(), word_vld);
    end
    start_frame();
    for (int i = 0; i < 4; i++) send_byte(8'(8'h20 + i));
    repeat (2) cyc();
    n_cmp++;
    if (q_data.size() != 1) begin
      n_err++;
      $display("FAIL arst_restart: got words=%0d want 1", q_data.size());
    end else if (q_data[0] !== 32'h20212223 || q_keep[0] !== 4'b1111 || q_last[0] !== 1'b0) begin
      n_err++;
      $display("FAIL arst_restart: got %h/%b/%b want 20212223/1111/0", q_data[0], q_keep[0], q_last[0]);
    end
  endtask

  task automatic test_pattern();
    logic exp_chk;
`ifdef SPI_RD_PATTERN_CHK_EN
    exp_chk = 1'b1;
`else
    exp_chk = 1'b0;
`endif
    word_rdy = 1'b1;
    start_frame();
    n_cmp++;
    if (chk_err !== 1'b0) begin
      n_err++;
      $display("FAIL chk_start: got %b want 0", chk_err);
    end
    for (int i = 0; i < 5; i++) send_byte(8'(i));
    n_cmp++;
    if (chk_err !== 1'b0) begin
      n_err++;
      $display("FAIL chk_clean: got %b want 0", chk_err);
    end
    send_byte(8'hAA);
    n_cmp++;
    if (chk_err !== exp_chk) begin
      n_err++;
      $display("FAIL chk_hit: got %b want %b", chk_err, exp_chk);
    end
    for (int i = 6; i < 10; i++) send_byte(8'(i));
    cyc();
    n_cmp++;
    if (chk_err !== exp_chk) begin
      n_err++;
      $display("FAIL chk_hold: got %b want %b", chk_err, exp_chk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_trunc();
    test_same_cycle();
    test_async_reset();
    test_pattern();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_rd_word_packer.md
Name: spi_rd_word_packer

Overview:
- Sits directly downstream of the SPI flash read engine.
- Consumes the byte stream that engine produces (one `byte_vld` pulse per received byte) and packs bytes into 32-bit words, MSB-first in flash-address order.
- Buffers packed words in a small FIFO and presents them on a valid/ready interface to the system bus side.
- Frame length is known in advance (`BYTE_MAX`), so the final partial word is flushed with a byte-keep mask and a last flag.

Parameters:
- `BYTE_MAX`, 10: bytes per read frame (1..255).
- `FIFO_DEPTH`, 2: output word FIFO entries (power of 2, ≥ 2).
- `START_VAL`, 8'h00: expected first byte value for the pattern checker (only used with the optional feature).

Ports:
- `sys_clk` input 1: system clock, all logic on rising edge.
- `sys_rst` input 1: asynchronous reset, active-high.
- `frame_start` input 1: one-cycle pulse when the read engine begins a new read frame.
- `byte_in` input 8: received byte from the read engine.
- `byte_vld` input 1: one-cycle qualifier for `byte_in`.
- `word_out` output 32: head-of-FIFO word; first byte of a word in [31:24].
- `word_keep` output 4: valid-byte mask, bit3 ↔ [31:24].
- `word_last` output 1: head word is the final word of the frame.
- `word_vld` output 1: FIFO non-empty.
- `word_rdy` input 1: consumer accepts the head word when `word_vld && word_rdy`.
- `frame_done` output 1: one-cycle pulse when byte `BYTE_MAX` of a frame is accepted.
- `trunc_err` output 1: one-cycle pulse when a frame is restarted before completion.
- `ovf` output 1: sticky flag; a completed word was dropped because the FIFO was full.
- `chk_err` output 1: sticky flag; pattern mismatch (see Optional Feature).

Behaviour:
- Reset (async, any time, including mid-frame):
  - All outputs 0; FIFO emptied; pack register, byte counter and lane index cleared; state IDLE.
- State machine:
  - IDLE → COLLECT on `frame_start`.
  - COLLECT → DONE when byte count reaches `BYTE_MAX`.
  - DONE → COLLECT on `frame_start`.
  - COLLECT → COLLECT on `frame_start`: restart. Partial pack register discarded, `trunc_err` pulses for 1 cycle, count cleared.
  - `byte_vld` in IDLE or DONE is ignored.
- Same-cycle `frame_start` and `byte_vld`: the new frame starts and that byte is accepted as byte 0 of the new frame.
- Packing:
  - Lane index 0..3; byte k of a frame goes to lane (k mod 4).
  - Lane 0 → [31:24], lane 3 → [7:0]; unused lanes read 0.
  - A word completes when lane 3 is written (keep 1111) or when the frame's final byte is written (keep = leading ones for lanes used, `last`=1).
  - If `BYTE_MAX` is a multiple of 4, the final full word carries `last`=1.
- Push timing:
  - A completed word is pushed on the same edge that accepts the completing byte.
  - `word_vld` rises the next cycle if the FIFO was empty (latency 1 cycle byte→word).
- FIFO:
  - First-word-fall-through; `word_out`/`word_keep`/`word_last` are registered from the head entry.
  - Pop on `word_vld && word_rdy`.
  - Simultaneous push and pop while full: both succeed, no overflow.
  - Push while full without pop: word dropped, `ovf` set (sticky until reset); frame counting continues.
- `frame_done` pulses on the cycle the final byte is accepted, regardless of FIFO state.
- Pointers wrap modulo `FIFO_DEPTH`; occupancy counter is `log2(FIFO_DEPTH)+1` bits.

Optional Feature:
- Macro: `SPI_RD_PATTERN_CHK_EN`.
- Defined:
  - Each accepted byte k is compared with (`START_VAL` + k) mod 256.
  - On mismatch, `chk_err` is set and held until reset or the next `frame_start`.
  - Checking covers flash pages initialised with an incrementing 00..FF pattern.
- Not defined:
  - No compare logic; `chk_err` tied to 0.

Test Plan:
- `BYTE_MAX`=10, `word_rdy`=1, `frame_start` then bytes 00..09 → words 00010203/keep 1111, 04050607/keep 1111, 08090000/keep 1100 with `last`=1; `frame_done` on byte 09; `ovf`=0.
- `FIFO_DEPTH`=2, `word_rdy`=0 for the whole frame of 00..09 → two words held, third dropped, `ovf`=1; raise `word_rdy` → exactly 00010203 then 04050607 delivered.
- `frame_start`, bytes 00..04, `frame_start` again → `trunc_err` 1-cycle pulse, partial byte 04 discarded; next bytes 10..19 → first word 10111213.
- `frame_start` and `byte_vld` (byte 55) in the same cycle → 55 lands in [31:24] of the first word of the frame.
- Assert `sys_rst` after 6 bytes with 1 word queued → all outputs 0 immediately; after release, `byte_vld` ignored until `frame_start`.
- With `SPI_RD_PATTERN_CHK_EN`, `START_VAL`=00, stream 00..09 with byte 5 = AA → `chk_err` rises on that byte and stays 1; without the macro → `chk_err` stays 0.
